// File: rtl/stall_arbiter_pkg.sv
// Shared widths, ID source-tag field, channel encodings and helpers for the stall arbiter.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

package stall_arbiter_pkg;

    localparam int ADDRESS_W  = `ADDRESS_WIDTH;
    localparam int ID_W_DEF   = `ID_WIDTH;

    // Source tag lives in the top nibble of the ID.
    localparam int ID_SRC_MSB = ID_W_DEF - 1;
    localparam int ID_SRC_LSB = ID_W_DEF - 4;

    localparam logic SRC_CH1 = 1'b0;
    localparam logic SRC_CH2 = 1'b1;

    typedef enum logic {
        RR_CH1 = 1'b0,
        RR_CH2 = 1'b1
    } rr_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {6'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/stall_fifo.sv
// Per-channel circular FIFO with live bits; flush ID comparators exist only
// when STALL_ARB_FLUSH_EN is defined.
module stall_fifo
    import stall_arbiter_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDRESS_W,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ID_W-1:0]   id_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [ID_W-1:0]   flush_id_i,
    output logic              full_o,
    output logic              head_live_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [ID_W-1:0]   head_id_o,
    output logic              dead_pop_o,
    output logic              drop_in_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][ID_W-1:0]   id_q;
    logic [DEPTH-1:0]             live_q, live_d;
    logic [DEPTH-1:0]             match;
    logic [PTR_W-1:0]             rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         match_in, empty, store, pop;

`ifdef STALL_ARB_FLUSH_EN
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            match[i] = flush_i && (id_q[i] == flush_id_i);
    end
    assign match_in = flush_i && (id_i == flush_id_i);
`else
    logic unused_flush;
    assign unused_flush = flush_i ^ (^flush_id_i);
    assign match        = '0;
    assign match_in     = 1'b0;
`endif

    assign empty       = (count_q == '0);
    assign full_o      = (count_q == CNT_W'(DEPTH));
    // Dead heads drain on their own, one per cycle, never reaching the arbiter.
    assign dead_pop_o  = !empty && !live_q[rd_ptr_q];
    assign pop         = pop_i || dead_pop_o;
    assign store       = push_i && !match_in;
    assign drop_in_o   = push_i && match_in;
    assign head_live_o = !empty && live_q[rd_ptr_q] && !match[rd_ptr_q];
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_id_o   = id_q[rd_ptr_q];
    assign count_d     = count_q + CNT_W'(store) - CNT_W'(pop);

    always_comb begin
        live_d = live_q & ~match;
        if (store)
            live_d[wr_ptr_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            wr_ptr_q <= wr_ptr_q + PTR_W'(store);
            count_q  <= count_d;
            live_q   <= live_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            addr_q[wr_ptr_q] <= addr_i;
            id_q[wr_ptr_q]   <= id_i;
        end
    end

endmodule

// File: rtl/stall_arbiter.sv
// Two stall-backpressured channel FIFOs merged round-robin onto one registered
// valid/ready output. ID-based flush is compiled in with STALL_ARB_FLUSH_EN.
module stall_arbiter
    import stall_arbiter_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDRESS_W,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_address_1,
    input  logic [ID_W-1:0]   in_id_1,
    input  logic              in_valid_1,
    output logic              out_stall_1,
    input  logic              flush_1,
    input  logic [ID_W-1:0]   flush_id_1,
    input  logic [ADDR_W-1:0] in_address_2,
    input  logic [ID_W-1:0]   in_id_2,
    input  logic              in_valid_2,
    output logic              out_stall_2,
    input  logic              flush_2,
    input  logic [ID_W-1:0]   flush_id_2,
    output logic [ADDR_W-1:0] out_address,
    output logic [ID_W-1:0]   out_id,
    output logic              out_valid,
    output logic              out_src,
    input  logic              out_ready,
    output logic [7:0]        drop_count
);

    logic              full_1, full_2, acc_1, acc_2;
    logic              live_1, live_2, dead_1, dead_2, dropin_1, dropin_2;
    logic [ADDR_W-1:0] haddr_1, haddr_2;
    logic [ID_W-1:0]   hid_1, hid_2;
    logic              load, gnt_1, gnt_2;
    rr_e               rr_q, rr_d;
    logic              out_valid_q, out_valid_d, out_src_q, out_src_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;

    assign acc_1 = in_valid_1 && !full_1;
    assign acc_2 = in_valid_2 && !full_2;

    stall_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ID_W(ID_W)) u_fifo_1 (
        .clk(clk), .reset(reset),
        .push_i(acc_1), .addr_i(in_address_1), .id_i(in_id_1),
        .pop_i(gnt_1), .flush_i(flush_1), .flush_id_i(flush_id_1),
        .full_o(full_1), .head_live_o(live_1), .head_addr_o(haddr_1),
        .head_id_o(hid_1), .dead_pop_o(dead_1), .drop_in_o(dropin_1)
    );

    stall_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ID_W(ID_W)) u_fifo_2 (
        .clk(clk), .reset(reset),
        .push_i(acc_2), .addr_i(in_address_2), .id_i(in_id_2),
        .pop_i(gnt_2), .flush_i(flush_2), .flush_id_i(flush_id_2),
        .full_o(full_2), .head_live_o(live_2), .head_addr_o(haddr_2),
        .head_id_o(hid_2), .dead_pop_o(dead_2), .drop_in_o(dropin_2)
    );

    assign load = !out_valid_q || out_ready;

    always_comb begin
        gnt_1 = 1'b0;
        gnt_2 = 1'b0;
        if (load) begin
            if (live_1 && live_2) begin
                gnt_1 = (rr_q == RR_CH1);
                gnt_2 = (rr_q == RR_CH2);
            end else begin
                gnt_1 = live_1;
                gnt_2 = live_2;
            end
        end
    end

    always_comb begin
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        out_addr_d  = out_addr_q;
        out_id_d    = out_id_q;
        if (load)
            out_valid_d = gnt_1 || gnt_2;
        if (gnt_1) begin
            rr_d       = RR_CH2;
            out_src_d  = SRC_CH1;
            out_addr_d = haddr_1;
            out_id_d   = hid_1;
        end else if (gnt_2) begin
            rr_d       = RR_CH1;
            out_src_d  = SRC_CH2;
            out_addr_d = haddr_2;
            out_id_d   = hid_2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q        <= RR_CH1;
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
            out_addr_q  <= '0;
            out_id_q    <= '0;
        end else begin
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            out_addr_q  <= out_addr_d;
            out_id_q    <= out_id_d;
        end
    end

`ifdef STALL_ARB_FLUSH_EN
    logic [7:0] drop_q, drop_d;
    // Up to two dead-head pops and two on-entry drops can land on one edge.
    assign drop_d = sat_add8(drop_q, 3'(dead_1) + 3'(dead_2) + 3'(dropin_1) + 3'(dropin_2));

    always_ff @(posedge clk) begin
        if (reset)
            drop_q <= '0;
        else
            drop_q <= drop_d;
    end
    assign drop_count = drop_q;
`else
    logic unused_drop;
    assign unused_drop = dead_1 ^ dead_2 ^ dropin_1 ^ dropin_2;
    assign drop_count  = 8'd0;
`endif

    assign out_stall_1 = full_1;
    assign out_stall_2 = full_2;
    assign out_valid   = out_valid_q;
    assign out_src     = out_src_q;
    assign out_address = out_addr_q;
    assign out_id      = out_id_q;

endmodule

// File: tb/tb_stall_arbiter.sv
// Directed bench for stall_arbiter: latency, stall/fill, fairness, flush and reset.
module tb_stall_arbiter;
    import stall_arbiter_pkg::*;

    localparam int AW = ADDRESS_W;
    localparam int IW = ID_W_DEF;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] in_address_1, in_address_2, out_address;
    logic [IW-1:0] in_id_1, in_id_2, flush_id_1, flush_id_2, out_id;
    logic          in_valid_1, in_valid_2, out_stall_1, out_stall_2;
    logic          flush_1, flush_2, out_valid, out_src, out_ready;
    logic [7:0]    drop_count;

    stall_arbiter #(.DEPTH(4), .ADDR_W(AW), .ID_W(IW)) dut (
        .clk(clk), .reset(reset),
        .in_address_1(in_address_1), .in_id_1(in_id_1), .in_valid_1(in_valid_1),
        .out_stall_1(out_stall_1), .flush_1(flush_1), .flush_id_1(flush_id_1),
        .in_address_2(in_address_2), .in_id_2(in_id_2), .in_valid_2(in_valid_2),
        .out_stall_2(out_stall_2), .flush_2(flush_2), .flush_id_2(flush_id_2),
        .out_address(out_address), .out_id(out_id), .out_valid(out_valid),
        .out_src(out_src), .out_ready(out_ready), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_err = 0;
    int            exp_dc = 0;
    logic [IW-1:0] q1[$];
    logic [IW-1:0] q2[$];
    logic [IW:0]   expq[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] id);
        return AW'(32'h1000) + (AW'(id) << 4);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present();
        in_valid_1 = (q1.size() != 0);
        in_id_1    = '0;
        if (in_valid_1) in_id_1 = q1[0];
        in_address_1 = addr_of(in_id_1);
        in_valid_2 = (q2.size() != 0);
        in_id_2    = '0;
        if (in_valid_2) in_id_2 = q2[0];
        in_address_2 = addr_of(in_id_2);
    endtask

    // One clock of both producers honouring stall; optionally score the output.
    task automatic cycle_drive(input bit check_out);
        logic        a1, a2;
        logic [IW:0] e;
        present();
        a1 = in_valid_1 && !out_stall_1;
        a2 = in_valid_2 && !out_stall_2;
        step();
        if (a1) void'(q1.pop_front());
        if (a2) void'(q2.pop_front());
        present();
        if (check_out && out_valid) begin
            e = {1'b1, {IW{1'b1}}};
            if (expq.size() != 0) e = expq.pop_front();
            chk("out_beat", {out_src, out_id}, e);
            chk("out_addr", out_address, addr_of(e[IW-1:0]));
        end
    endtask

    task automatic run(input int budget);
        int c = 0;
        while ((q1.size() + q2.size() + expq.size()) != 0 && c < budget) begin
            cycle_drive(1'b1);
            c++;
        end
        chk("drained", q1.size() + q2.size() + expq.size(), 0);
        q1.delete(); q2.delete(); expq.delete();
        present();
        step();
        chk("idle_after", out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; out_ready = 1'b0;
        flush_1 = 1'b0; flush_2 = 1'b0; flush_id_1 = '0; flush_id_2 = '0;
        present();
        step(); step();
        chk("rst_valid", out_valid, 0);
        chk("rst_stall1", out_stall_1, 0);
        chk("rst_stall2", out_stall_2, 0);
        chk("rst_id", out_id, 0);
        chk("rst_drop", drop_count, 0);
        reset = 1'b0;

        // single beat: two-edge latency
        out_ready = 1'b1;
        in_valid_1 = 1'b1; in_id_1 = IW'(8'h11); in_address_1 = AW'(4);
        step();
        in_valid_1 = 1'b0;
        chk("lat_edge_n", out_valid, 0);
        step();
        chk("lat_valid", out_valid, 1);
        chk("lat_id", out_id, 8'h11);
        chk("lat_src", out_src, 0);
        chk("lat_addr", out_address, 4);
        step();
        chk("lat_consumed", out_valid, 0);

        // fill and stall with the output register already occupied
        out_ready = 1'b0;
        q1.push_back(IW'(8'h12));
        cycle_drive(1'b0); cycle_drive(1'b0);
        chk("fill_hold_id", out_id, 8'h12);
        for (int i = 0; i < 5; i++) q2.push_back(IW'(8'h21 + i));
        for (int i = 0; i < 4; i++) begin
            chk("fill_stall_low", out_stall_2, 0);
            cycle_drive(1'b0);
        end
        chk("fill_stall_high", out_stall_2, 1);
        chk("fill_held", q2.size(), 1);
        cycle_drive(1'b0); cycle_drive(1'b0);
        chk("fill_stall_stays", out_stall_2, 1);
        chk("fill_held2", q2.size(), 1);
        chk("hold_valid", out_valid, 1);
        chk("hold_id", out_id, 8'h12);
        chk("hold_src", out_src, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) expq.push_back({1'b1, IW'(8'h21 + i)});
        run(30);

        // fairness: both channels streaming
        for (int i = 0; i < 4; i++) begin
            q1.push_back(IW'(8'h30 + i));
            q2.push_back(IW'(8'h40 + i));
            expq.push_back({1'b0, IW'(8'h30 + i)});
            expq.push_back({1'b1, IW'(8'h40 + i)});
        end
        run(40);

`ifdef STALL_ARB_FLUSH_EN
        // buffered flush of a middle entry
        out_ready = 1'b0;
        q1.push_back(IW'(8'h14));
        cycle_drive(1'b0); cycle_drive(1'b0);
        chk("bf_hold_id", out_id, 8'h14);
        q1.push_back(IW'(8'h15)); q1.push_back(IW'(8'h16)); q1.push_back(IW'(8'h17));
        cycle_drive(1'b0); cycle_drive(1'b0); cycle_drive(1'b0);
        flush_1 = 1'b1; flush_id_1 = IW'(8'h16);
        step();
        flush_1 = 1'b0;
        out_ready = 1'b1;
        expq.push_back({1'b0, IW'(8'h15)});
        expq.push_back({1'b0, IW'(8'h17)});
        run(20);
        exp_dc++;
        chk("bf_drop", drop_count, exp_dc);

        // incoming beat flushed on entry
        in_valid_1 = 1'b1; in_id_1 = IW'(8'h16); in_address_1 = addr_of(IW'(8'h16));
        flush_1 = 1'b1; flush_id_1 = IW'(8'h16);
        step();
        flush_1 = 1'b0; in_valid_1 = 1'b0;
        chk("in_flush_v0", out_valid, 0);
        step();
        chk("in_flush_v1", out_valid, 0);
        exp_dc++;
        chk("in_flush_drop", drop_count, exp_dc);

        // flush ID differing only in the source tag must not match
        in_valid_1 = 1'b1; in_id_1 = IW'(8'h16); in_address_1 = addr_of(IW'(8'h16));
        flush_1 = 1'b1; flush_id_1 = IW'(8'h96);
        step();
        flush_1 = 1'b0; in_valid_1 = 1'b0;
        expq.push_back({1'b0, IW'(8'h16)});
        run(10);
        chk("tag_nomatch_drop", drop_count, exp_dc);

        // head flush while grantable; channel 2 same ID is untouched
        in_valid_1 = 1'b1; in_id_1 = IW'(8'h16); in_address_1 = addr_of(IW'(8'h16));
        in_valid_2 = 1'b1; in_id_2 = IW'(8'h16); in_address_2 = addr_of(IW'(8'h16));
        step();
        in_valid_1 = 1'b0; in_valid_2 = 1'b0;
        flush_1 = 1'b1; flush_id_1 = IW'(8'h16);
        step();
        flush_1 = 1'b0;
        chk("hf_valid", out_valid, 1);
        chk("hf_src", out_src, 1);
        chk("hf_id", out_id, 8'h16);
        q1.push_back(IW'(8'h19));
        expq.push_back({1'b0, IW'(8'h19)});
        run(10);
        exp_dc++;
        chk("hf_drop", drop_count, exp_dc);
`else
        // flush inputs are ignored in this build
        in_valid_1 = 1'b1; in_id_1 = IW'(8'h16); in_address_1 = addr_of(IW'(8'h16));
        flush_1 = 1'b1; flush_id_1 = IW'(8'h16);
        step();
        flush_1 = 1'b0; in_valid_1 = 1'b0;
        expq.push_back({1'b0, IW'(8'h16)});
        run(10);
        chk("noflush_drop", drop_count, exp_dc);
`endif

        // reset mid-stream with both FIFOs full; channel 2 is next in line before reset
        out_ready = 1'b0;
        q1.push_back(IW'(8'h50));
        cycle_drive(1'b0);
        for (int i = 1; i < 5; i++) q1.push_back(IW'(8'h50 + i));
        for (int i = 0; i < 4; i++) q2.push_back(IW'(8'h60 + i));
        for (int i = 0; i < 8; i++) cycle_drive(1'b0);
        chk("pre_rst_stall1", out_stall_1, 1);
        chk("pre_rst_stall2", out_stall_2, 1);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_id", out_id, 8'h50);
        q1.delete(); q2.delete();
        present();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_id", out_id, 0);
        chk("mid_rst_addr", out_address, 0);
        chk("mid_rst_src", out_src, 0);
        chk("mid_rst_stall1", out_stall_1, 0);
        chk("mid_rst_stall2", out_stall_2, 0);
        chk("mid_rst_drop", drop_count, 0);
        out_ready = 1'b1;
        q1.push_back(IW'(8'h70));
        q2.push_back(IW'(8'h71));
        expq.push_back({1'b0, IW'(8'h70)});
        expq.push_back({1'b1, IW'(8'h71)});
        run(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stall_arbiter.md
# stall_arbiter

- Sits directly downstream of the dual-channel producer.
- Accepts two independent address/ID streams through per-channel stall backpressure and buffers each stream in its own FIFO.
- Applies producer-issued flushes by discarding buffered beats whose ID matches the flush ID.
- Merges the surviving beats round-robin onto a single registered valid/ready output.

## Interface
- DEPTH, 4: entries per channel FIFO; power of two, minimum 2.
- ADDR_W, `ADDRESS_WIDTH: address width.
- ID_W, `ID_WIDTH: ID width; bits [ID_W-1:ID_W-4] carry the source tag.
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- in_address_k  in  ADDR_W  channel k beat address (k = 1, 2).
- in_id_k  in  ID_W  channel k beat ID.
- in_valid_k  in  1  channel k beat present.
- out_stall_k  out  1  channel k backpressure; the producer holds its beat while high.
- flush_k  in  1  one-cycle flush request for channel k.
- flush_id_k  in  ID_W  ID to discard on channel k.
- out_address  out  ADDR_W  merged beat address.
- out_id  out  ID_W  merged beat ID.
- out_valid  out  1  merged beat present.
- out_src  out  1  0 = channel 1, 1 = channel 2.
- out_ready  in  1  downstream accepts the beat this cycle.
- drop_count  out  8  saturating count of beats discarded by flush.

## Operation
- **Accept.** accept_k = in_valid_k & !out_stall_k.
  - out_stall_k = (count_k == DEPTH).
  - out_stall_k is decoded from registered state only, with no input dependence.
  - out_stall_k stays high while full, even in a cycle where the channel pops.
- **Entry format.** Each FIFO entry holds {live, id, address}. Push writes live = 1.
- **Flush** (flush_k high):
  - Every entry of FIFO k with id == flush_id_k has live cleared on that edge.
  - An incoming beat on channel k in the same cycle with in_id_k == flush_id_k is accepted but not stored; no stall is applied for it.
  - Flush compares all bits of the ID.
  - Flush never touches the other channel's FIFO or the output register.
- **Dead heads.** A head entry with live = 0 is popped without output, one per cycle per channel. It increments drop_count (saturating at 255) on pop. Beats dropped on entry also increment drop_count.
- **Arbitration.**
  - The output register loads when !out_valid | out_ready.
  - Candidates are the channels whose head is live, excluding any head matching an active flush this cycle.
  - A round-robin pointer picks among the candidates and flips to the other channel after each grant.
  - Single candidate: it is granted.
  - No candidate: out_valid drops to 0 if the register was consumed.
- **Output hold.** While out_valid & !out_ready, out_address, out_id and out_src stay stable.
- **Same-edge push and pop.** A push and a pop on the same FIFO in the same edge leaves the count unchanged.
- **Reset** (synchronous): all FIFOs empty, all outputs 0, both out_stall_k = 0, round-robin pointer = channel 1, drop_count = 0. Reset asserted mid-operation discards all buffered beats.

## Timing
- Beat accepted at edge N into an empty FIFO, with the output register free: out_valid is high after edge N+1. Minimum latency is 2 edges and there is no bypass.
- Throughput: one output beat per cycle while out_ready is held high.
- Stall release: count_k drops below DEPTH at edge N, so out_stall_k is low during cycle N+1.
- Flush takes effect at the same edge on which flush_k is sampled. A matching head at that edge is never granted.

## Configuration
- **STALL_ARB_FLUSH_EN defined:** flush logic as above is compiled in.
- **STALL_ARB_FLUSH_EN undefined:**
  - flush_k and flush_id_k are ignored.
  - Every accepted beat is stored live.
  - drop_count is tied to 0.
  - No ID comparators are instantiated.

## Structure
- Shared defines:
  - ADDRESS_WIDTH and ID_WIDTH, already present.
  - New ID_SRC_MSB/ID_SRC_LSB constants for the source-tag field.
  - New SRC_CH1/SRC_CH2 encodings.
- Sub-module stall_fifo (parameters DEPTH, ADDR_W, ID_W):
  - Circular buffer with a count of width $clog2(DEPTH)+1 and wrap-around read/write pointers.
  - Per-entry live bits, plus a flush port with parallel ID comparators.
  - Instantiated twice.
- The top level holds the arbiter, output register and drop counter.

## Test plan
- **Single beat.** Channel 1 presents {addr 0x04, id 0x11}, out_ready = 1 → out_valid is high 2 edges later with out_id 0x11, out_src 0.
- **Fill and stall.** out_ready = 0; channel 2 streams ids 0x21, 0x22, … → after 4 accepts out_stall_2 = 1 and 0x25 is held by the producer. Raising out_ready releases the beats in order, and 0x25 is accepted after the stall drops.
- **Fairness.** Both channels stream continuously with out_ready = 1 → out_src alternates 0, 1, 0, 1 and no ID is lost or duplicated.
- **Buffered flush.** Channel 1 FIFO holds 0x15, 0x16, 0x17 and flush_1 pulses with flush_id 0x16 → output shows 0x15 then 0x17, and drop_count = 1.
- **Incoming and head flush.** Flush 0x16 arrives in the same cycle as incoming 0x16, and again with 0x16 at the head while out_ready = 1 → 0x16 never appears on the output and drop_count increments once per case.
- **Reset mid-stream.** reset is asserted for 1 cycle while both FIFOs are full and out_valid = 1 → the next cycle shows all outputs 0 and out_stall_1/2 = 0. The first subsequent grant goes to channel 1.
